// File: rtl/spi_seg_pkg.sv
// Shared constants for the SPI segment receiver.
// Opcodes, FSM state encoding, status tag and frame length.
package spi_seg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int BYTE_BITS = FRAME_BITS / 2;

  localparam logic [2:0] STATUS_TAG = 3'b101;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_SEG   = 2'b01;
  localparam logic [1:0] OP_BLINK = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    WAIT_CS
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with rise/fall pulses from one history flop.
// Ports: clk, rst_n (sync, active low), d_i raw pin, rise_o, fall_o.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              lvl;

  assign lvl = sync_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= lvl;
    end
  end

  assign rise_o = lvl & ~prev_q;
  assign fall_o = ~lvl & prev_q;

endmodule

// File: rtl/spi_segment_rx.sv
// SPI mode-0 slave: 16-bit cmd/data frames, seg/blink regs, status on MISO.
// Ports: clk, rst_n, ena, spi_* pins, seg_out, blink_div, frame_valid/err.
module spi_segment_rx
  import spi_seg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] seg_out,
  output logic [7:0] blink_div,
  output logic       frame_valid,
  output logic       frame_err
);

  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  sync_edge_det #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sck (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (spi_sck),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  // CS_N idles high so reset must not fake an edge
  sync_edge_det #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (spi_cs_n),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  // same depth as SCK keeps each bit aligned with its edge
  always_ff @(posedge clk) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
  end

  assign mosi_s = mosi_q[SYNC_STAGES-1];

  state_e      state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  seg_q, seg_d;
  logic [7:0]  blink_q, blink_d;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ld_q, ld_d;
  logic        ovr_q, ovr_d;
  logic        lerr_q, lerr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        cs_low_q, cs_low_d;
  logic        commit;
  logic [7:0]  status;

  localparam logic [2:0] LAST_BIT = 3'(BYTE_BITS - 1);

  assign status = {cnt_q, lerr_q, STATUS_TAG};

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    op_d     = op_q;
    seg_d    = seg_q;
    blink_d  = blink_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    ld_d     = ld_q;
    ovr_d    = ovr_q;
    lerr_d   = lerr_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    commit   = 1'b0;
    cs_low_d = cs_low_q;
    if (cs_fall) cs_low_d = 1'b1;
    if (cs_rise) cs_low_d = 1'b0;

    if (!ena) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            bit_d   = '0;
            sh_d    = '0;
            ld_d    = 1'b0;
            ovr_d   = 1'b0;
            state_d = CMD;
          end
        end
        CMD: begin
          if (sck_rise) begin
            cmd_d = {cmd_q[6:0], mosi_s};
            bit_d = bit_q + 3'd1;
            if (bit_q == LAST_BIT) begin
              op_d    = cmd_d[7:6];
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (sck_rise) begin
            data_d = {data_q[6:0], mosi_s};
            bit_d  = bit_q + 3'd1;
            if (bit_q == LAST_BIT) begin
              commit  = 1'b1;
              state_d = WAIT_CS;
            end
          end
          // first fall in DATA follows the 8th rise
          if (sck_fall) begin
            if (!ld_q) begin
              sh_d = status;
              ld_d = 1'b1;
            end else begin
              sh_d = {sh_q[6:0], 1'b0};
            end
          end
        end
        WAIT_CS: begin
          if (sck_rise) begin
            ovr_d  = 1'b1;
            lerr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (commit) begin
        valid_d = 1'b1;
        cnt_d   = cnt_q + 4'd1;
        lerr_d  = 1'b0;
        unique case (1'b1)
          (op_q == OP_SEG):   seg_d   = data_d;
          (op_q == OP_BLINK): blink_d = data_d;
          default: ;
        endcase
      end

      // SCK edge above is applied before a same-cycle CS_N rise
      if (cs_rise && state_q != IDLE) begin
        if (state_d == WAIT_CS) begin
          err_d = ovr_d;
        end else begin
          err_d  = 1'b1;
          lerr_d = 1'b1;
        end
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      op_q     <= OP_NOP;
      seg_q    <= '0;
      blink_q  <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      ld_q     <= 1'b0;
      ovr_q    <= 1'b0;
      lerr_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cs_low_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      op_q     <= op_d;
      seg_q    <= seg_d;
      blink_q  <= blink_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      ld_q     <= ld_d;
      ovr_q    <= ovr_d;
      lerr_q   <= lerr_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      cs_low_q <= cs_low_d;
    end
  end

  assign spi_miso    = (state_q == DATA) & sh_q[7];
  assign spi_miso_oe = cs_low_q & ena;
  assign seg_out     = seg_q;
  assign blink_div   = blink_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_spi_segment_rx.sv
// Bench for spi_segment_rx: vector table, corner sequences, random frames.
// Random frames are checked against a frame-level model of the registers.
module tb_spi_segment_rx;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] seg_out;
  logic [7:0] blink_div;
  logic       frame_valid;
  logic       frame_err;

  spi_segment_rx #(
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .spi_sck    (sck),
    .spi_cs_n   (cs_n),
    .spi_mosi   (mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .seg_out    (seg_out),
    .blink_div  (blink_div),
    .frame_valid(frame_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int vcnt = 0;
  int ecnt = 0;

  // cycles high, so a stretched pulse counts more than once
  always @(negedge clk) begin
    if (frame_valid === 1'b1) vcnt = vcnt + 1;
    if (frame_err === 1'b1) ecnt = ecnt + 1;
  end

  logic [7:0] m_seg, m_blink;
  int         m_cnt;
  bit         m_lerr;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input bit chk_vals);
    @(negedge clk);
    rst_n = 1'b0;
    cs_n = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    if (chk_vals) begin
      chk("rst_seg", seg_out, 0);
      chk("rst_blink", blink_div, 0);
      chk("rst_valid", frame_valid, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_miso", spi_miso, 0);
      chk("rst_oe", spi_miso_oe, 0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    m_seg = 8'h00;
    m_blink = 8'h00;
    m_cnt = 0;
    m_lerr = 1'b0;
  endtask

  task automatic pulse(input logic b);
    mosi = b;
    repeat (HALF) @(negedge clk);
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  // Full CS_N-framed transfer of n SCK pulses; returns data-byte MISO.
  task automatic xfer(input logic [15:0] w, input int n,
                      input bit lat, output logic [7:0] mb);
    bit oe_bad;
    bit early;
    mb = 8'h00;
    oe_bad = 1'b0;
    early = 1'b0;
    vcnt = 0;
    ecnt = 0;
    @(negedge clk);
    cs_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i < 16) mosi = w[15-i];
      else mosi = 1'($urandom_range(1));
      repeat (HALF) @(negedge clk);
      if (spi_miso_oe !== 1'b1) oe_bad = 1'b1;
      if (i >= 8 && i < 16) mb[15-i] = spi_miso;
      sck = 1'b1;
      if (lat && i == 15) begin
        for (int k = 0; k <= SYNC; k++) begin
          @(posedge clk);
          #1;
          if (k < SYNC && frame_valid !== 1'b0) early = 1'b1;
        end
        chk("valid_early", early, 0);
        chk("valid_latency", frame_valid, 1);
        repeat (HALF - SYNC - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    if (spi_miso_oe !== 1'b1) oe_bad = 1'b1;
    cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    chk("oe_cs_low", oe_bad, 0);
    chk("oe_idle", spi_miso_oe, 0);
  endtask

  // Frame-level effect of a transfer of n pulses.
  task automatic model(input logic [15:0] w, input int n,
                       output int ev, output int ee,
                       output logic [7:0] st);
    st = {4'(m_cnt), m_lerr, 3'b101};
    if (n < 16) begin
      ev = 0;
      ee = 1;
      m_lerr = 1'b1;
    end else begin
      ev = 1;
      if (w[15:14] == 2'd1) m_seg = w[7:0];
      if (w[15:14] == 2'd2) m_blink = w[7:0];
      m_cnt = (m_cnt + 1) % 16;
      m_lerr = 1'b0;
      ee = (n > 16) ? 1 : 0;
      if (n > 16) m_lerr = 1'b1;
    end
  endtask

  typedef struct {
    logic [15:0] word;
    int          n;
    bit          lat;
    logic [7:0]  seg;
    logic [7:0]  blink;
    int          v;
    int          e;
    bit          mchk;
    logic [7:0]  miso;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] mb;
  logic [15:0] w;
  int         n, ev, ee;
  logic [7:0] st;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{16'h40A5, 16, 1'b0, 8'hA5, 8'h00, 1, 0, 1'b1, 8'h05};
    tbl[1] = '{16'h8010, 16, 1'b1, 8'hA5, 8'h10, 1, 0, 1'b1, 8'h15};
    tbl[2] = '{16'h40FF, 11, 1'b0, 8'hA5, 8'h10, 0, 1, 1'b0, 8'h00};
    tbl[3] = '{16'hC000, 16, 1'b0, 8'hA5, 8'h10, 1, 0, 1'b1, 8'h2D};
    tbl[4] = '{16'h403C, 17, 1'b0, 8'h3C, 8'h10, 1, 1, 1'b1, 8'h35};
    tbl[5] = '{16'hC000, 16, 1'b0, 8'h3C, 8'h10, 1, 0, 1'b1, 8'h4D};

    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      xfer(tbl[i].word, tbl[i].n, tbl[i].lat, mb);
      chk($sformatf("t%0d_seg", i), seg_out, tbl[i].seg);
      chk($sformatf("t%0d_blink", i), blink_div, tbl[i].blink);
      chk($sformatf("t%0d_valid", i), vcnt, tbl[i].v);
      chk($sformatf("t%0d_err", i), ecnt, tbl[i].e);
      if (tbl[i].mchk) chk($sformatf("t%0d_miso", i), mb, tbl[i].miso);
    end

    // read-back after two good frames from reset
    do_reset(1'b0);
    xfer(16'h4011, 16, 1'b0, mb);
    xfer(16'h8022, 16, 1'b0, mb);
    xfer(16'hC000, 16, 1'b0, mb);
    chk("rd_miso", mb, 8'h25);
    chk("rd_seg", seg_out, 8'h11);
    chk("rd_blink", blink_div, 8'h22);
    chk("rd_valid", vcnt, 1);
    chk("rd_err", ecnt, 0);

    // reset in the middle of a frame
    vcnt = 0;
    ecnt = 0;
    @(negedge clk);
    cs_n = 1'b0;
    w = 16'h40FF;
    for (int i = 0; i < 12; i++) pulse(w[15-i]);
    do_reset(1'b1);
    chk("mrst_err", ecnt, 0);
    chk("mrst_valid", vcnt, 0);
    xfer(16'h4081, 16, 1'b0, mb);
    chk("mrst_seg", seg_out, 8'h81);
    chk("mrst_err2", ecnt, 0);

    // ena dropped mid-frame discards it silently
    vcnt = 0;
    ecnt = 0;
    @(negedge clk);
    cs_n = 1'b0;
    w = 16'h40AA;
    for (int i = 0; i < 10; i++) pulse(w[15-i]);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    chk("ena_oe", spi_miso_oe, 0);
    ena = 1'b1;
    for (int i = 10; i < 16; i++) pulse(w[15-i]);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    chk("ena_seg", seg_out, 8'h81);
    chk("ena_valid", vcnt, 0);
    chk("ena_err", ecnt, 0);

    // random frames against the model
    do_reset(1'b0);
    for (int r = 0; r < 40; r++) begin
      w = 16'($urandom);
      if ($urandom_range(9) < 6) n = 16;
      else n = $urandom_range(18, 1);
      model(w, n, ev, ee, st);
      xfer(w, n, 1'b0, mb);
      chk($sformatf("r%0d_seg", r), seg_out, m_seg);
      chk($sformatf("r%0d_blink", r), blink_div, m_blink);
      chk($sformatf("r%0d_valid", r), vcnt, ev);
      chk($sformatf("r%0d_err", r), ecnt, ee);
      if (n >= 16) chk($sformatf("r%0d_miso", r), mb, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
